// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring RV32M divide/remainder unit (DIV, DIVU, REM, REMU)
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      r_state;
    logic            r_is_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [CW-1:0]   r_cnt;
    logic [XLEN:0]   r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_div;
    logic [XLEN-1:0] r_result;

    logic            w_signed;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_trial;
    logic [XLEN:0]   w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_calc_res;

    // Operand conditioning and special-case detection on the issuing cycle
    always_comb begin
        w_signed      = ~div_op[0];
        w_abs_a       = (w_signed && a[XLEN-1]) ? -a : a;
        w_abs_b       = (w_signed && b[XLEN-1]) ? -b : b;
        w_div0        = (b == '0);
        w_ovf         = w_signed && (a == MOST_NEG) && (b == '1);
        w_special_res = w_div0 ? (div_op[1] ? a : '1) : (div_op[1] ? '0 : a);
    end

    // One restoring step; the 33-bit trial keeps the borrow as its sign bit
    always_comb begin
        w_shift    = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
        w_trial    = w_shift - {1'b0, r_div};
        w_rem_nx   = w_trial[XLEN] ? w_shift : w_trial;
        w_quo_nx   = {r_quo[XLEN-2:0], ~w_trial[XLEN]};
        w_calc_res = r_is_rem ? (r_neg_r ? -w_rem_nx[XLEN-1:0] : w_rem_nx[XLEN-1:0])
                              : (r_neg_q ? -w_quo_nx : w_quo_nx);
    end

    // Control FSM and datapath registers; result only loads on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_is_rem <= div_op[1];
                    r_neg_q  <= w_signed & (a[XLEN-1] ^ b[XLEN-1]);
                    r_neg_r  <= w_signed & a[XLEN-1];
                    r_div    <= w_abs_b;
                    r_quo    <= w_abs_a;
                    r_rem    <= '0;
                    r_cnt    <= CW'(XLEN-1);
                    if (w_div0 || w_ovf) begin
                        r_state  <= S_DONE;
                        r_result <= w_special_res;
                    end else begin
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state  <= S_DONE;
                        r_result <= w_calc_res;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
endmodule
